awmc_water_arbiter: RTL and testbench

//  Shares one water-inlet supply and one drain pump between N_MACH washing-machine controllers (laundromat bank).

---
 rtl/awmc_arb_pkg.sv | 16 +
 rtl/awmc_rr_channel.sv | 131 +++++++++++++
 rtl/awmc_water_arbiter.sv | 60 ++++++
 tb/tb_awmc_water_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awmc_arb_pkg.sv
// Shared definitions for the laundromat water arbiter.
//   ch_state_e      : per-channel state (idle / granted / dead-time handover)
//   *_DEF constants : default bank size, hold limit and dead-time length
package awmc_arb_pkg;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'b00,
    CH_GRANT    = 2'b01,
    CH_HANDOVER = 2'b10
  } ch_state_e;

  localparam int N_MACH_DEF      = 4;
  localparam int MAX_HOLD_DEF    = 8;
  localparam int DEAD_CYCLES_DEF = 2;

endpackage

// File: rtl/awmc_rr_channel.sv
// One round-robin arbitration channel (inlet valve or drain pump).
//   clk, reset    : clock, asynchronous active-high reset
//   tick          : timebase strobe used to age the current owner's hold time
//   supply_ok     : 0 forces the grant off and restarts the dead-time
//   req           : per-machine request levels
//   gnt           : registered one-hot (or zero) grant
//   owner         : index of the current / most recent owner
//   preempt_evt   : combinational, one bit set on the cycle the owner is preempted
module awmc_rr_channel
  import awmc_arb_pkg::*;
#(
  parameter int N_MACH      = N_MACH_DEF,
  parameter int OWN_W       = $clog2(N_MACH),
  parameter int MAX_HOLD    = MAX_HOLD_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              supply_ok,
  input  logic [N_MACH-1:0] req,
  output logic [N_MACH-1:0] gnt,
  output logic [OWN_W-1:0]  owner,
  output logic [N_MACH-1:0] preempt_evt
);

  // The dead counter holds DEAD_CYCLES-1 down to 0.
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  ch_state_e         state_q, state_d;
  logic [OWN_W-1:0]  ptr_q, ptr_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [N_MACH-1:0] gnt_q, gnt_d;
  logic [7:0]        hold_q, hold_d;
  logic [DW-1:0]     dead_q, dead_d;
  logic [OWN_W-1:0]  pick;
  logic [OWN_W-1:0]  owner_next;

  // First requester at or after the pointer, wrapping around the bank.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_MACH-1:0] r,
                                               input logic [OWN_W-1:0]  p);
    logic [OWN_W-1:0] idx;
    rr_pick = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = N_MACH - 1; i >= 0; i--) begin
      idx = OWN_W'((int'(p) + i) % N_MACH);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick       = rr_pick(req, ptr_q);
  assign owner_next = (owner_q == OWN_W'(N_MACH - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    hold_d      = hold_q;
    dead_d      = dead_q;
    preempt_evt = '0;

    if (!supply_ok) begin
      // Supply fault: drop everything and restart break-before-make; the
      // round-robin pointer is left where it was.
      state_d = CH_HANDOVER;
      gnt_d   = '0;
      dead_d  = DW'(DEAD_CYCLES - 1);
    end else begin
      unique case (state_q)
        CH_IDLE: begin
          if (|req) begin
            owner_d      = pick;
            gnt_d        = '0;
            gnt_d[pick]  = 1'b1;
            hold_d       = '0;
            state_d      = CH_GRANT;
          end
        end
        CH_GRANT: begin
          // A voluntary release is checked first, so it beats preemption.
          if (!req[owner_q]) begin
            gnt_d   = '0;
            ptr_d   = owner_next;
            dead_d  = DW'(DEAD_CYCLES - 1);
            state_d = CH_HANDOVER;
          end else if ((hold_q == 8'(MAX_HOLD)) && |(req & ~gnt_q)) begin
            gnt_d                = '0;
            ptr_d                = owner_next;
            dead_d               = DW'(DEAD_CYCLES - 1);
            state_d              = CH_HANDOVER;
            preempt_evt[owner_q] = 1'b1;
          end else if (tick && (hold_q < 8'(MAX_HOLD))) begin
            hold_d = hold_q + 8'd1;
          end
        end
        CH_HANDOVER: begin
          if (dead_q == '0) state_d = CH_IDLE;
          else              dead_d  = dead_q - 1'b1;
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CH_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      dead_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;

endmodule

// File: rtl/awmc_water_arbiter.sv
// Shares one water inlet and one drain pump between N_MACH washer controllers.
//   clk, reset              : clock, asynchronous active-high reset
//   tick                    : 1-clk timebase strobe
//   supply_ok               : 0 = mains water / pump fault, forces all grants off
//   inlet_req, drain_req    : per-machine request levels
//   inlet_gnt, drain_gnt    : one-hot or zero grants gating the physical valves
//   inlet_owner, drain_owner: current / last owner index per channel
//   preempt                 : 1-clk pulse per machine that lost a grant to the hold limit
//   fault                   : registered !supply_ok
module awmc_water_arbiter
  import awmc_arb_pkg::*;
#(
  parameter int N_MACH      = N_MACH_DEF,
  parameter int OWN_W       = $clog2(N_MACH),
  parameter int MAX_HOLD    = MAX_HOLD_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              supply_ok,
  input  logic [N_MACH-1:0] inlet_req,
  input  logic [N_MACH-1:0] drain_req,
  output logic [N_MACH-1:0] inlet_gnt,
  output logic [N_MACH-1:0] drain_gnt,
  output logic [OWN_W-1:0]  inlet_owner,
  output logic [OWN_W-1:0]  drain_owner,
  output logic [N_MACH-1:0] preempt,
  output logic              fault
);

  logic [N_MACH-1:0] inlet_pre_evt;
  logic [N_MACH-1:0] drain_pre_evt;

  awmc_rr_channel #(
    .N_MACH(N_MACH), .OWN_W(OWN_W), .MAX_HOLD(MAX_HOLD), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_inlet (
    .clk(clk), .reset(reset), .tick(tick), .supply_ok(supply_ok),
    .req(inlet_req), .gnt(inlet_gnt), .owner(inlet_owner), .preempt_evt(inlet_pre_evt)
  );

  awmc_rr_channel #(
    .N_MACH(N_MACH), .OWN_W(OWN_W), .MAX_HOLD(MAX_HOLD), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_drain (
    .clk(clk), .reset(reset), .tick(tick), .supply_ok(supply_ok),
    .req(drain_req), .gnt(drain_gnt), .owner(drain_owner), .preempt_evt(drain_pre_evt)
  );

  // OR-merge means a machine preempted on both channels at once sees one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preempt <= '0;
      fault   <= 1'b0;
    end else begin
      preempt <= inlet_pre_evt | drain_pre_evt;
      fault   <= ~supply_ok;
    end
  end

endmodule

// File: tb/tb_awmc_water_arbiter.sv
module tb_awmc_water_arbiter;

  localparam int N      = 4;
  localparam int MAXH   = 8;
  localparam int DEAD   = 2;
  localparam int STARVE_BOUND = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       supply_ok;
  logic [3:0] inlet_req;
  logic [3:0] drain_req;
  logic [3:0] inlet_gnt;
  logic [3:0] drain_gnt;
  logic [1:0] inlet_owner;
  logic [1:0] drain_owner;
  logic [3:0] preempt;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  awmc_water_arbiter #(
    .N_MACH(N), .OWN_W(2), .MAX_HOLD(MAXH), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .supply_ok(supply_ok),
    .inlet_req(inlet_req), .drain_req(drain_req),
    .inlet_gnt(inlet_gnt), .drain_gnt(drain_gnt),
    .inlet_owner(inlet_owner), .drain_owner(drain_owner),
    .preempt(preempt), .fault(fault)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (channel 0 = inlet, 1 = drain) -------
  int         m_owner [2];   // -1 when nobody holds the channel
  int         m_gap   [2];   // blank cycles still owed before arbitration
  int         m_held  [2];   // ticks seen by the current owner
  int         m_ptr   [2];
  int         m_last  [2];
  logic [3:0] e_preempt;
  logic       e_fault;

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_find(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int idx = (p + k) % N;
      if (((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  task model_reset();
    for (int c = 0; c < 2; c++) begin
      m_owner[c] = -1; m_gap[c] = 0; m_held[c] = 0; m_ptr[c] = 0; m_last[c] = 0;
    end
    e_preempt = '0;
    e_fault   = 1'b0;
  endtask

  task chan_step(input int c, input logic [3:0] r);
    logic [3:0] others;
    int w;
    if (!supply_ok) begin
      m_owner[c] = -1;
      m_gap[c]   = DEAD;
    end else if (m_owner[c] >= 0) begin
      others = r & ~(4'd1 << m_owner[c]);
      if (((r >> m_owner[c]) & 4'd1) == 4'd0) begin
        m_ptr[c] = (m_owner[c] + 1) % N; m_owner[c] = -1; m_gap[c] = DEAD;
      end else if (m_held[c] == MAXH && others != 4'd0) begin
        e_preempt = e_preempt | (4'd1 << m_owner[c]);
        m_ptr[c] = (m_owner[c] + 1) % N; m_owner[c] = -1; m_gap[c] = DEAD;
      end else if (tick && m_held[c] < MAXH) begin
        m_held[c]++;
      end
    end else if (m_gap[c] > 0) begin
      m_gap[c]--;
    end else begin
      w = rr_find(r, m_ptr[c]);
      if (w >= 0) begin
        m_owner[c] = w; m_last[c] = w; m_held[c] = 0;
      end
    end
  endtask

  task model_step();
    e_preempt = '0;
    chan_step(0, inlet_req);
    chan_step(1, drain_req);
    e_fault = ~supply_ok;
  endtask

  function automatic logic [3:0] gnt_of(input int o);
    return (o < 0) ? 4'd0 : (4'd1 << o);
  endfunction

  task compare_all();
    check("inlet_gnt",   32'(inlet_gnt),   32'(gnt_of(m_owner[0])));
    check("drain_gnt",   32'(drain_gnt),   32'(gnt_of(m_owner[1])));
    check("inlet_owner", 32'(inlet_owner), 32'(m_last[0]));
    check("drain_owner", 32'(drain_owner), 32'(m_last[1]));
    check("preempt",     32'(preempt),     32'(e_preempt));
    check("fault",       32'(fault),       32'(e_fault));
    check("inlet_onehot", 32'($countones(inlet_gnt) <= 1), 32'd1);
    check("drain_onehot", 32'($countones(drain_gnt) <= 1), 32'd1);
  endtask

  // Drive inputs, advance one edge, update the model, compare #1 after the edge.
  task step(input logic t, input logic s, input logic [3:0] ir, input logic [3:0] dr);
    tick = t; supply_ok = s; inlet_req = ir; drain_req = dr;
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    compare_all();
    cyc++;
  endtask

  // Asserted away from any edge; outputs must clear before the next edge.
  task do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_inlet_gnt", 32'(inlet_gnt),   32'd0);
    check("rst_drain_gnt", 32'(drain_gnt),   32'd0);
    check("rst_inlet_own", 32'(inlet_owner), 32'd0);
    check("rst_drain_own", 32'(drain_owner), 32'd0);
    check("rst_preempt",   32'(preempt),     32'd0);
    check("rst_fault",     32'(fault),       32'd0);
    tick = 1'b0; supply_ok = 1'b1; inlet_req = '0; drain_req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int gseq[$];
  int pseq[$];
  int gaps[$];
  int ons[$];
  int run_len;
  int drops;
  int pulses;
  int pulse_idx;
  int waitc [2][4];
  int max_wait;
  logic [3:0] prev_g;
  logic [3:0] ir;
  logic [3:0] dr;
  logic [3:0] flip;

  initial begin
    reset = 1'b1; tick = 1'b0; supply_ok = 1'b1; inlet_req = '0; drain_req = '0;
    model_reset();
    #3;

    // 1: single request, latency, release and dead-time
    do_reset();
    step(1'b0, 1'b1, 4'b0100, 4'b0000);
    check("t1_gnt", 32'(inlet_gnt), 32'h4);
    check("t1_owner", 32'(inlet_owner), 32'd2);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    check("t1_release", 32'(inlet_gnt), 32'h0);
    check("t1_owner_kept", 32'(inlet_owner), 32'd2);
    step(1'b0, 1'b1, 4'b0100, 4'b0000);
    check("t1_dead1", 32'(inlet_gnt), 32'h0);
    step(1'b0, 1'b1, 4'b0100, 4'b0000);
    check("t1_dead2", 32'(inlet_gnt), 32'h0);
    step(1'b0, 1'b1, 4'b0100, 4'b0000);
    check("t1_regrant", 32'(inlet_gnt), 32'h4);

    // 2: three contenders, preemption rotation 0 -> 1 -> 3 -> 0
    do_reset();
    prev_g = '0; run_len = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, 1'b1, 4'b1011, 4'b0000);
      if (preempt != 4'd0) pseq.push_back($clog2(int'(preempt)));
      if (inlet_gnt != prev_g) begin
        if (prev_g == 4'd0) begin
          if (gseq.size() > 0) gaps.push_back(run_len);
          gseq.push_back($clog2(int'(inlet_gnt)));
        end else ons.push_back(run_len);
        run_len = 0;
      end
      run_len++;
      prev_g = inlet_gnt;
    end
    check("t2_grant_count", 32'(gseq.size() >= 4), 32'd1);
    if (gseq.size() >= 4) begin
      check("t2_g0", 32'(gseq[0]), 32'd0);
      check("t2_g1", 32'(gseq[1]), 32'd1);
      check("t2_g2", 32'(gseq[2]), 32'd3);
      check("t2_g3", 32'(gseq[3]), 32'd0);
    end
    check("t2_pre_count", 32'(pseq.size() >= 3), 32'd1);
    if (pseq.size() >= 3) begin
      check("t2_p0", 32'(pseq[0]), 32'd0);
      check("t2_p1", 32'(pseq[1]), 32'd1);
      check("t2_p2", 32'(pseq[2]), 32'd3);
    end
    if (gaps.size() >= 2) begin
      check("t2_gap0", 32'(gaps[0]), 32'(DEAD + 1));
      check("t2_gap1", 32'(gaps[1]), 32'(DEAD + 1));
    end else check("t2_gap_count", 32'(gaps.size()), 32'd2);
    if (ons.size() >= 1) check("t2_on_len", 32'(ons[0]), 32'(MAXH + 1));
    else check("t2_on_count", 32'(ons.size()), 32'd1);

    // 3: single requester never preempted
    do_reset();
    drops = 0; pulses = 0;
    step(1'b1, 1'b1, 4'b0100, 4'b0000);
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 1'b1, 4'b0100, 4'b0000);
      if (inlet_gnt != 4'b0100) drops++;
      if (preempt != 4'd0) pulses++;
    end
    check("t3_drops", 32'(drops), 32'd0);
    check("t3_pulses", 32'(pulses), 32'd0);

    // 4: supply fault while machine 1 owns the inlet
    do_reset();
    step(1'b1, 1'b1, 4'b0010, 4'b0000);
    check("t4_gnt", 32'(inlet_gnt), 32'h2);
    step(1'b1, 1'b0, 4'b0010, 4'b0000);
    check("t4_fault_gnt", 32'(inlet_gnt), 32'h0);
    check("t4_fault", 32'(fault), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'b0010, 4'b0000);
    step(1'b1, 1'b1, 4'b0010, 4'b0000);
    check("t4_restore_fault", 32'(fault), 32'd0);
    check("t4_restore_dead1", 32'(inlet_gnt), 32'h0);
    step(1'b1, 1'b1, 4'b0010, 4'b0000);
    check("t4_restore_dead2", 32'(inlet_gnt), 32'h0);
    step(1'b1, 1'b1, 4'b0010, 4'b0000);
    check("t4_regrant", 32'(inlet_gnt), 32'h2);
    check("t4_owner", 32'(inlet_owner), 32'd1);

    // 5: machine 0 preempted on both channels on the same edge
    do_reset();
    pulses = 0; pulse_idx = -1;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b1, 4'b0011, 4'b0011);
      if (preempt != 4'd0) begin
        pulses++;
        pulse_idx = k;
        check("t5_pre_val", 32'(preempt), 32'h1);
        check("t5_inlet_drop", 32'(inlet_gnt), 32'h0);
        check("t5_drain_drop", 32'(drain_gnt), 32'h0);
      end
    end
    check("t5_pulses", 32'(pulses), 32'd1);
    check("t5_pulse_idx", 32'(pulse_idx), 32'(MAXH + 1));

    // 6: asynchronous reset mid-grant, then random soak
    step(1'b1, 1'b1, 4'b0001, 4'b0001);
    step(1'b1, 1'b1, 4'b0001, 4'b0001);
    step(1'b1, 1'b1, 4'b0001, 4'b0001);
    step(1'b1, 1'b1, 4'b0001, 4'b0001);
    check("t6_pre_reset_gnt", 32'(inlet_gnt), 32'h1);
    do_reset();

    ir = '0; dr = '0; max_wait = 0;
    for (int c = 0; c < 2; c++) for (int m = 0; m < 4; m++) waitc[c][m] = 0;
    for (int k = 0; k < 3000; k++) begin
      flip = '0;
      for (int m = 0; m < 4; m++) if ($urandom_range(0, 7) == 0) flip = flip | (4'd1 << m);
      ir = ir ^ flip;
      flip = '0;
      for (int m = 0; m < 4; m++) if ($urandom_range(0, 7) == 0) flip = flip | (4'd1 << m);
      dr = dr ^ flip;
      step(1'(k % 2), ($urandom_range(0, 63) != 0), ir, dr);
      for (int m = 0; m < 4; m++) begin
        if (!supply_ok || ((ir >> m) & 4'd1) == 4'd0 || ((inlet_gnt >> m) & 4'd1) != 4'd0)
          waitc[0][m] = 0;
        else waitc[0][m]++;
        if (!supply_ok || ((dr >> m) & 4'd1) == 4'd0 || ((drain_gnt >> m) & 4'd1) != 4'd0)
          waitc[1][m] = 0;
        else waitc[1][m]++;
        if (waitc[0][m] > max_wait) max_wait = waitc[0][m];
        if (waitc[1][m] > max_wait) max_wait = waitc[1][m];
      end
    end
    check("t6_starvation", 32'(max_wait <= STARVE_BOUND), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
